// File: rtl/ubuffer_fifo.sv
// ubuffer_fifo: parametrised elastic buffer following the single-stage UBuffer
// register in the GRNG core. Circular store of DEPTH words of SIZE bits with
// valid/ready handshakes on both sides. in_ready, out_valid and count are decoded
// from registers only, so there is no combinational path between the two sides.
//
// Optional feature: define UBUFFER_FIFO_FLUSH_EN to add a synchronous flush
// input that clears pointers and count (storage contents are kept).
module ubuffer_fifo #(
  parameter int unsigned SIZE  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
`ifdef UBUFFER_FIFO_FLUSH_EN
  input  logic                     flush,
`endif
  input  logic [SIZE-1:0]          value,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [SIZE-1:0]          buff_value,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [SIZE-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic [AW-1:0]   w_wr_ptr_d;
  logic [AW-1:0]   w_rd_ptr_d;
  logic [CW-1:0]   w_count_d;
  logic            w_in_ready;
  logic            w_out_valid;
  logic            w_push;
  logic            w_pop;
  logic            w_wr_en;

  // Handshake flags come from the registered count only; a pop on a full
  // buffer therefore cannot open the input in the same cycle.
  assign w_in_ready  = (r_count != CW'(DEPTH));
  assign w_out_valid = (r_count != '0);
  assign w_push      = in_valid && w_in_ready;
  assign w_pop       = w_out_valid && out_ready;

  assign in_ready    = w_in_ready;
  assign out_valid   = w_out_valid;
  assign count       = r_count;
  assign buff_value  = r_mem[r_rd_ptr];

  // Next-state for pointers and occupancy; DEPTH is a power of two so the
  // pointers wrap naturally at their own width.
  always_comb begin
    w_wr_ptr_d = r_wr_ptr;
    w_rd_ptr_d = r_rd_ptr;
    w_count_d  = r_count;
    w_wr_en    = w_push;

    if (w_push) begin
      w_wr_ptr_d = r_wr_ptr + AW'(1);
    end
    if (w_pop) begin
      w_rd_ptr_d = r_rd_ptr + AW'(1);
    end

    unique case ({w_push, w_pop})
      2'b10:   w_count_d = r_count + CW'(1);
      2'b01:   w_count_d = r_count - CW'(1);
      default: w_count_d = r_count;
    endcase

`ifdef UBUFFER_FIFO_FLUSH_EN
    // Flush overrides any push or pop; the offered word is discarded.
    if (flush) begin
      w_wr_ptr_d = '0;
      w_rd_ptr_d = '0;
      w_count_d  = '0;
      w_wr_en    = 1'b0;
    end
`endif
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_d;
      r_rd_ptr <= w_rd_ptr_d;
      r_count  <= w_count_d;
    end
  end

  // Storage; cleared on reset so buff_value reads zero until the first push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[r_wr_ptr] <= value;
    end
  end

endmodule

// File: tb/tb_ubuffer_fifo.sv
// Self-checking bench for ubuffer_fifo: reference queue scoreboard, a vector
// table for the fill/overflow/drain sequence, hand-written corner sequences,
// and order checks on SIZE=21 and SIZE=4 instances.
module tb_ubuffer_fifo;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [31:0] value;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] buff_value;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  count;

  logic [20:0] a_value, a_buff;
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [3:0]  a_count;
  logic [3:0]  b_value, b_buff;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [1:0]  b_count;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] sb_q[$];

  ubuffer_fifo #(.SIZE(32), .DEPTH(DEPTH)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef UBUFFER_FIFO_FLUSH_EN
    .flush      (flush),
`endif
    .value      (value),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .buff_value (buff_value),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .count      (count)
  );

  ubuffer_fifo #(.SIZE(21), .DEPTH(8)) u_dut21 (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef UBUFFER_FIFO_FLUSH_EN
    .flush      (1'b0),
`endif
    .value      (a_value),
    .in_valid   (a_in_valid),
    .in_ready   (a_in_ready),
    .buff_value (a_buff),
    .out_valid  (a_out_valid),
    .out_ready  (a_out_ready),
    .count      (a_count)
  );

  ubuffer_fifo #(.SIZE(4), .DEPTH(2)) u_dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef UBUFFER_FIFO_FLUSH_EN
    .flush      (1'b0),
`endif
    .value      (b_value),
    .in_valid   (b_in_valid),
    .in_ready   (b_in_ready),
    .buff_value (b_buff),
    .out_valid  (b_out_valid),
    .out_ready  (b_out_ready),
    .count      (b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] v;
    logic        ordy;
    int          cnt;
    logic        ir;
    logic        ov;
    logic        chk_val;
    logic [31:0] val;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // One cycle: drive inputs, predict from the reference queue, clock, compare.
  task automatic step(input logic iv, input logic [31:0] v, input logic ordy);
    logic do_push, do_pop, fl;
    in_valid  = iv;
    value     = v;
    out_ready = ordy;
    fl        = flush;
    do_push   = iv && (sb_q.size() != int'(DEPTH)) && !fl;
    do_pop    = ordy && (sb_q.size() != 0) && !fl;
    chk("in_ready", {31'b0, in_ready}, {31'b0, sb_q.size() != int'(DEPTH)});
    chk("out_valid", {31'b0, out_valid}, {31'b0, sb_q.size() != 0});
    if (ordy && sb_q.size() != 0) chk("pop_data", buff_value, sb_q[0]);
    @(posedge clk);
    #1;
    if (fl) sb_q.delete();
    if (do_pop) void'(sb_q.pop_front());
    if (do_push) sb_q.push_back(v);
    chk("count", {29'b0, count}, 32'(sb_q.size()));
  endtask

  initial begin
    // Fill, overflow attempt, drain, pop while empty.
    tbl[0] = '{1'b1, 32'hFFFF_FFFF, 1'b0, 1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF};
    tbl[1] = '{1'b1, 32'h789A_BCDE, 1'b0, 2, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF};
    tbl[2] = '{1'b1, 32'h0123_CDEF, 1'b0, 3, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF};
    tbl[3] = '{1'b1, 32'h0000_0001, 1'b0, 4, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF};
    tbl[4] = '{1'b1, 32'h5555_5555, 1'b0, 4, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF};
    tbl[5] = '{1'b0, 32'h0,         1'b1, 3, 1'b1, 1'b1, 1'b1, 32'h789A_BCDE};
    tbl[6] = '{1'b0, 32'h0,         1'b1, 2, 1'b1, 1'b1, 1'b1, 32'h0123_CDEF};
    tbl[7] = '{1'b0, 32'h0,         1'b1, 1, 1'b1, 1'b1, 1'b1, 32'h0000_0001};
    tbl[8] = '{1'b0, 32'h0,         1'b1, 0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[9] = '{1'b0, 32'h0,         1'b1, 0, 1'b1, 1'b0, 1'b0, 32'h0};

    rst_n = 1'b0;
    flush = 1'b0;
    value = '0; in_valid = 1'b0; out_ready = 1'b0;
    a_value = '0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    b_value = '0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", {29'b0, count}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_buff_value", buff_value, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].iv, tbl[i].v, tbl[i].ordy);
      chk("tbl_count", {29'b0, count}, 32'(tbl[i].cnt));
      chk("tbl_in_ready", {31'b0, in_ready}, {31'b0, tbl[i].ir});
      chk("tbl_out_valid", {31'b0, out_valid}, {31'b0, tbl[i].ov});
      if (tbl[i].chk_val) chk("tbl_buff_value", buff_value, tbl[i].val);
    end

    // Streaming at count=2; pointers wrap several times.
    step(1'b1, 32'hC000_0001, 1'b0);
    step(1'b1, 32'hC000_0002, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'hA000_0000 + 32'(i), 1'b1);
      chk("stream_count", {29'b0, count}, 32'd2);
    end
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);

    // Full buffer with simultaneous push and pop: push refused.
    for (int i = 0; i < 4; i++) step(1'b1, 32'hB000_0000 + 32'(i), 1'b0);
    step(1'b1, 32'hDEAD_BEEF, 1'b1);
    chk("full_sim_count", {29'b0, count}, 32'd3);
    step(1'b1, 32'h8000_0000, 1'b0);
    chk("full_next_count", {29'b0, count}, 32'd4);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);

    // Asynchronous reset mid-stream at count=3.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h7000_0000 + 32'(i), 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    chk("arst_count", {29'b0, count}, 32'd0);
    chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_buff_value", buff_value, 32'd0);
    chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 32'h1234_5678, 1'b0);
    step(1'b0, 32'h0, 1'b1);

`ifdef UBUFFER_FIFO_FLUSH_EN
    for (int i = 0; i < 3; i++) step(1'b1, 32'h6000_0000 + 32'(i), 1'b0);
    flush = 1'b1;
    step(1'b1, 32'hFACE_CAFE, 1'b0);
    flush = 1'b0;
    chk("flush_count", {29'b0, count}, 32'd0);
    chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
    step(1'b1, 32'h0BAD_F00D, 1'b0);
    step(1'b0, 32'h0, 1'b1);
`endif

    // Order check on narrow instances, including top-bit-set patterns.
    begin
      logic [20:0] q21[$];
      logic [3:0]  q4[$];
      for (int i = 0; i < 8; i++) begin
        a_in_valid = 1'b1;
        a_value    = 21'(32'h9E37_79B9 * 32'(i + 1));
        q21.push_back(a_value);
        b_in_valid = (i < 2);
        b_value    = 4'(4'hF - 4'(i * 7));
        if (i < 2) q4.push_back(b_value);
        @(posedge clk);
        #1;
      end
      a_in_valid = 1'b0;
      b_in_valid = 1'b0;
      chk("w21_full_count", {28'b0, a_count}, 32'd8);
      chk("w21_in_ready", {31'b0, a_in_ready}, 32'd0);
      chk("w4_full_count", {30'b0, b_count}, 32'd2);
      a_out_ready = 1'b1;
      b_out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
        chk("w21_order", {11'b0, a_buff}, {11'b0, q21[i]});
        if (i < 2) chk("w4_order", {28'b0, b_buff}, {28'b0, q4[i]});
        @(posedge clk);
        #1;
      end
      a_out_ready = 1'b0;
      b_out_ready = 1'b0;
      chk("w21_empty", {31'b0, a_out_valid}, 32'd0);
      chk("w4_empty", {31'b0, b_out_valid}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ubuffer_fifo.md
# ubuffer_fifo

Parametrised elastic buffer succeeding the single-stage `UBuffer` register in the GRNG core. Holds up to `DEPTH` words of `SIZE` bits in a circular store with valid/ready handshakes on both sides. This decouples a sample producer (URNG / transform stage) from a consumer that may stall. Output data is registered storage, so the block also breaks timing paths the way `UBuffer` does.

## Interface
- `SIZE`, 32: data width in bits, ≥1.
- `DEPTH`, 4: number of entries; power of two, ≥2.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `value`  input  SIZE  write data.
- `in_valid`  input  1  producer offers `value` this cycle.
- `in_ready`  output  1  buffer can accept a word this cycle.
- `buff_value`  output  SIZE  head-of-queue data.
- `out_valid`  output  1  `buff_value` holds a valid word.
- `out_ready`  input  1  consumer takes `buff_value` this cycle.
- `count`  output  $clog2(DEPTH)+1  number of stored words, 0..DEPTH.
- `flush`  input  1  synchronous clear; present only with `UBUFFER_FIFO_FLUSH_EN`.

## Operation
- Push when `in_valid && in_ready` at a rising edge: `value` is written to `mem[wr_ptr]`, and `wr_ptr` increments modulo DEPTH.
- Pop when `out_valid && out_ready` at a rising edge: `rd_ptr` increments modulo DEPTH.
- `in_ready = (count != DEPTH)`. It depends only on registered state, with no combinational path from `out_ready`. When full, a simultaneous pop does not enable a push in the same cycle.
- `out_valid = (count != 0)`.
- `buff_value = mem[rd_ptr]` at all times. When empty it shows stale storage, or zero after reset, and consumers must ignore it.
- Count update:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged, both pointers advance
  - neither: unchanged
- Word order is strict FIFO. No data is ever dropped or duplicated.
- `in_valid` while full: the word is not accepted, state is unchanged, and the producer must hold it.
- `out_ready` while empty: no effect.
- Data is treated as an opaque bit vector; signedness is irrelevant (signed/unsigned values pass bit-exact).
- Reset (`rst_n` low, asynchronous, at any time including mid-transfer):
  - `wr_ptr`, `rd_ptr`, `count` go to 0; all `mem` entries go to 0.
  - Outputs: `in_ready`=1, `out_valid`=0, `count`=0, `buff_value`=0.
  - Deassertion is synchronous to `clk` upstream; the first push is possible at the first rising edge after release.

## Timing
- Latency: a word pushed at edge N is visible on `buff_value`/`out_valid` immediately after edge N (one cycle, matching `UBuffer`).
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- Full-to-not-full: after a pop at edge N on a full buffer, `in_ready` rises after edge N.
- `in_ready`, `out_valid` and `count` are decoded from registers only.

## Configuration
- `UBUFFER_FIFO_FLUSH_EN` defined: adds the `flush` input. `flush` high at a rising edge sets `wr_ptr`, `rd_ptr` and `count` to 0, overriding any push or pop in that cycle; `mem` contents are retained. Afterwards `out_valid`=0 and `in_ready`=1. Reset has priority over flush.
- Not defined: no `flush` port and no flush logic; the buffer can only be cleared by `rst_n`.

## Test plan
- Reset, then push 32'hFFFF_FFFF with `out_ready`=0 → one cycle later `out_valid`=1, `buff_value`=32'hFFFF_FFFF, `count`=1.
- Push 32'hFFFF_FFFF, 32'h789A_BCDE, 32'h0123_CDEF, 32'h0000_0001 (DEPTH=4), then assert `in_valid` with 32'h5555_5555 → `count`=4, `in_ready`=0, word not stored. Drain → the four words appear in order, then `out_valid`=0.
- Streaming with `in_valid`=`out_ready`=1 for 10 cycles from count=2 → `count` stays 2, pointers wrap past DEPTH, outputs in strict order.
- Full buffer with push and pop in the same cycle → pop happens, push refused, `count`=3; next cycle push accepted, `count`=4.
- Assert `rst_n` low asynchronously mid-stream at count=3 → immediately `count`=0, `out_valid`=0, `buff_value`=0, `in_ready`=1.
- With `UBUFFER_FIFO_FLUSH_EN` and count=3, `flush`=1 together with a push → `count`=0, `out_valid`=0, pushed word discarded; SIZE=4 and SIZE=21 instances pass the same order check.
